rtype_instr_encoder: RTL and testbench

Encoder counterpart to the R-type instruction controller. It takes ALU-op-level requests (alu_op, rd, rs1, rs2) over a valid/ready stream and encodes each into a 32-bit RV32I R-type instruction word. The words are buffered in a small FIFO and written sequentially into instruction memory through a write port with backpressure. The bench and program loader use it to fill instruction memory with R-type programs that the decode path then executes.

---
 rtl/rv_pkg.sv | 55 +++++
 rtl/rtype_instr_encoder_if.sv | 33 +++
 rtl/sync_fifo.sv | 50 +++++
 rtl/rtype_instr_encoder.sv | 121 ++++++++++++
 tb/tb_rtype_instr_encoder.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I R-type encodings used by the encoder and the decode controller
package rv_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
   localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_DONE = ST_DONE;

   function automatic logic is_legal_op(input logic [3:0] op);
      return op <= ALU_AND;
   endfunction

   // Unknown ops collapse to add x0,x0,x0 so the program slot is still filled.
   function automatic logic [31:0] encode_rtype(input logic [3:0] op, input logic [4:0] rd,
                                                input logic [4:0] rs1, input logic [4:0] rs2);
      logic [2:0] f3;
      logic [6:0] f7;
      f7 = FUNCT7_BASE;
      case (op)
         ALU_ADD, ALU_SUB: f3 = 3'b000;
         ALU_SLL:          f3 = 3'b001;
         ALU_SLT:          f3 = 3'b010;
         ALU_SLTU:         f3 = 3'b011;
         ALU_XOR:          f3 = 3'b100;
         ALU_SRL, ALU_SRA: f3 = 3'b101;
         ALU_OR:           f3 = 3'b110;
         ALU_AND:          f3 = 3'b111;
         default:          f3 = 3'b000;
      endcase
      if (op == ALU_SUB || op == ALU_SRA) f7 = FUNCT7_ALT;
      if (!is_legal_op(op)) return {25'd0, OPCODE_RTYPE};
      return {f7, rs2, rs1, f3, rd, OPCODE_RTYPE};
   endfunction

endpackage

// File: rtl/rtype_instr_encoder_if.sv
// rtl/rtype_instr_encoder_if.sv - control, request stream and memory write port of the encoder
interface rtype_instr_encoder_if #(
   parameter int INSTR_WIDTH  = 32,
   parameter int ALU_OP_WIDTH = 4,
   parameter int ADDR_WIDTH   = 8
);
   logic                    start;
   logic [ADDR_WIDTH-1:0]   base_addr;
   logic [ADDR_WIDTH:0]     num_instr;
   logic                    in_valid;
   logic                    in_ready;
   logic [ALU_OP_WIDTH-1:0] in_alu_op;
   logic [4:0]              in_rd;
   logic [4:0]              in_rs1;
   logic [4:0]              in_rs2;
   logic                    mem_we;
   logic                    mem_ready;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [INSTR_WIDTH-1:0]  mem_wdata;
   logic                    busy;
   logic                    done;
   logic                    illegal_op;

   modport master (
      output start, base_addr, num_instr, in_valid, in_alu_op, in_rd, in_rs1, in_rs2, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, illegal_op
   );

   modport slave (
      input  start, base_addr, num_instr, in_valid, in_alu_op, in_rd, in_rs1, in_rs2, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, illegal_op
   );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; head reads as zero when empty
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/rtype_instr_encoder.sv
// rtl/rtype_instr_encoder.sv - encodes ALU-op requests into R-type words and streams them into instruction memory
module rtype_instr_encoder
   import rv_pkg::*;
#(
   parameter int INSTR_WIDTH  = 32,
   parameter int ALU_OP_WIDTH = 4,
   parameter int ADDR_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   rtype_instr_encoder_if.slave  bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [1:0]              state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH:0]     num_q, num_d;
   logic [ADDR_WIDTH:0]     accepted_q, accepted_d;
   logic [ADDR_WIDTH:0]     written_q, written_d;
   logic                    illegal_q, illegal_d;
   logic                    done_q, done_d;
   logic                    enc_valid_q, enc_valid_d;
   logic [INSTR_WIDTH-1:0]  enc_word_q, enc_word_d;

   logic [ALU_OP_WIDTH-1:0] op;
   logic [CNT_W-1:0]        fifo_count, occupancy;
   logic                    fifo_full, fifo_empty;
   logic                    in_ready, accept, pop;

   // The encode register counts as occupied so a word in flight always finds a free slot.
   assign op        = bus.in_alu_op;
   assign occupancy = fifo_count + {{(CNT_W-1){1'b0}}, enc_valid_q};
   assign in_ready  = (state_q == S_RUN) && (occupancy < DEPTH_C) && (accepted_q < num_q);
   assign accept    = bus.in_valid && in_ready;
   assign pop       = !fifo_empty && bus.mem_ready;

   assign bus.in_ready   = in_ready;
   assign bus.mem_we     = !fifo_empty;
   assign bus.mem_addr   = addr_q;
   assign bus.busy       = (state_q == S_RUN);
   assign bus.done       = done_q;
   assign bus.illegal_op = illegal_q;

   sync_fifo #(.WIDTH(INSTR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (enc_valid_q),
      .wdata_i (enc_word_q),
      .pop_i   (pop),
      .rdata_o (bus.mem_wdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      num_d       = num_q;
      accepted_d  = accepted_q;
      written_d   = written_q;
      illegal_d   = illegal_q;
      done_d      = (state_q == S_DONE);
      enc_valid_d = accept;
      enc_word_d  = accept ? encode_rtype(op, bus.in_rd, bus.in_rs1, bus.in_rs2) : enc_word_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               num_d      = bus.num_instr;
               addr_d     = bus.base_addr;
               accepted_d = '0;
               written_d  = '0;
               illegal_d  = 1'b0;
               state_d    = (bus.num_instr == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (accept) begin
               accepted_d = accepted_q + 1'b1;
               if (!is_legal_op(op)) illegal_d = 1'b1;
            end
            if (pop) begin
               addr_d    = addr_q + 1'b1;
               written_d = written_q + 1'b1;
               if (written_q + 1'b1 == num_q) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         num_q       <= '0;
         accepted_q  <= '0;
         written_q   <= '0;
         illegal_q   <= 1'b0;
         done_q      <= 1'b0;
         enc_valid_q <= 1'b0;
         enc_word_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         num_q       <= num_d;
         accepted_q  <= accepted_d;
         written_q   <= written_d;
         illegal_q   <= illegal_d;
         done_q      <= done_d;
         enc_valid_q <= enc_valid_d;
         enc_word_q  <= enc_word_d;
      end
   end

   logic unused_full;
   assign unused_full = fifo_full;
endmodule

// File: tb/tb_rtype_instr_encoder.sv
// tb/tb_rtype_instr_encoder.sv - directed self-checking bench for rtype_instr_encoder
module tb_rtype_instr_encoder;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   done_cnt;
   logic [7:0]  log_a [$];
   logic [31:0] log_d [$];

   rtype_instr_encoder_if #(.INSTR_WIDTH(32), .ALU_OP_WIDTH(4), .ADDR_WIDTH(8)) bus ();

   rtype_instr_encoder #(.INSTR_WIDTH(32), .ALU_OP_WIDTH(4), .ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handshakes are observed mid-cycle; the following rising edge completes them.
   always @(negedge clk) begin
      if (!rst && bus.mem_we && bus.mem_ready) begin
         log_a.push_back(bus.mem_addr);
         log_d.push_back(bus.mem_wdata);
      end
      if (bus.done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_load(input logic [7:0] base, input logic [8:0] num);
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.num_instr = num;
      tick();
      bus.start     = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      int c;
      c = 0;
      bus.in_valid  = 1'b1;
      bus.in_alu_op = op;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      while (!bus.in_ready && c < 200) begin
         tick();
         c++;
      end
      if (c >= 200) begin
         total++;
         bad++;
         $error("FAIL send_timeout observed=%0d expected<200", c);
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int c;
      c = 0;
      while (done_cnt == d0 && c < 200) begin
         tick();
         c++;
      end
      if (c >= 200) begin
         total++;
         bad++;
         $error("FAIL done_timeout observed=%0d expected<200", c);
      end
      tick();
      tick();
   endtask

   initial begin
      int d0;
      int k;
      int i;
      logic [3:0]  st_op [6];
      logic [31:0] st_w  [6];
      total = 0;
      bad = 0;
      done_cnt = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.base_addr = '0;
      bus.num_instr = '0;
      bus.in_valid = 1'b0;
      bus.in_alu_op = '0;
      bus.in_rd = '0;
      bus.in_rs1 = '0;
      bus.in_rs2 = '0;
      bus.mem_ready = 1'b1;
      st_op = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      st_w  = '{32'h002080B3, 32'h40208133, 32'h002091B3, 32'h0020A233, 32'h0020B2B3, 32'h0020C333};

      tick();
      tick();
      check("rst_in_ready",   32'(bus.in_ready), 32'd0);
      check("rst_mem_we",     32'(bus.mem_we), 32'd0);
      check("rst_mem_addr",   32'(bus.mem_addr), 32'd0);
      check("rst_mem_wdata",  bus.mem_wdata, 32'd0);
      check("rst_busy",       32'(bus.busy), 32'd0);
      check("rst_done",       32'(bus.done), 32'd0);
      check("rst_illegal",    32'(bus.illegal_op), 32'd0);
      rst = 1'b0;
      tick();

      // single add
      log_a.delete(); log_d.delete(); d0 = done_cnt;
      start_load(8'h10, 9'd1);
      check("t1_busy", 32'(bus.busy), 32'd1);
      send(4'd0, 5'd3, 5'd1, 5'd2);
      wait_done(d0);
      check("t1_count", 32'(log_a.size()), 32'd1);
      check("t1_addr",  32'(log_a[0]), 32'h10);
      check("t1_data",  log_d[0], 32'h002081B3);
      check("t1_done",  32'(done_cnt - d0), 32'd1);
      check("t1_busy_fall", 32'(bus.busy), 32'd0);

      // sub / sra with funct7 alternate
      log_a.delete(); log_d.delete(); d0 = done_cnt;
      start_load(8'h30, 9'd2);
      send(4'd1, 5'd5, 5'd6, 5'd7);
      send(4'd7, 5'd10, 5'd11, 5'd12);
      wait_done(d0);
      check("t2_count", 32'(log_a.size()), 32'd2);
      check("t2_addr0", 32'(log_a[0]), 32'h30);
      check("t2_data0", log_d[0], 32'h407302B3);
      check("t2_addr1", 32'(log_a[1]), 32'h31);
      check("t2_data1", log_d[1], 32'h40C5D533);

      // address wrap
      log_a.delete(); log_d.delete(); d0 = done_cnt;
      start_load(8'hFE, 9'd4);
      send(4'd9, 5'd1, 5'd2, 5'd3);
      send(4'd9, 5'd2, 5'd2, 5'd3);
      send(4'd9, 5'd3, 5'd2, 5'd3);
      send(4'd9, 5'd4, 5'd2, 5'd3);
      wait_done(d0);
      check("t3_count", 32'(log_a.size()), 32'd4);
      check("t3_addr0", 32'(log_a[0]), 32'hFE);
      check("t3_addr1", 32'(log_a[1]), 32'hFF);
      check("t3_addr2", 32'(log_a[2]), 32'h00);
      check("t3_addr3", 32'(log_a[3]), 32'h01);
      check("t3_data0", log_d[0], 32'h003170B3);
      check("t3_data1", log_d[1], 32'h00317133);
      check("t3_data2", log_d[2], 32'h003171B3);
      check("t3_data3", log_d[3], 32'h00317233);

      // backpressure: memory stalled for 10 cycles with 6 requests offered
      log_a.delete(); log_d.delete(); d0 = done_cnt;
      bus.mem_ready = 1'b0;
      start_load(8'h20, 9'd6);
      k = 0;
      for (i = 0; i < 10; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_alu_op = st_op[k];
         bus.in_rd     = 5'(k + 1);
         bus.in_rs1    = 5'd1;
         bus.in_rs2    = 5'd2;
         if (i == 5) begin
            check("t4_stall_addr_mid", 32'(bus.mem_addr), 32'h20);
            check("t4_stall_data_mid", bus.mem_wdata, 32'h002080B3);
         end
         if (bus.in_ready) begin
            tick();
            k++;
         end else begin
            tick();
         end
      end
      check("t4_accepted", 32'(k), 32'd4);
      check("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("t4_we_held", 32'(bus.mem_we), 32'd1);
      check("t4_addr_held", 32'(bus.mem_addr), 32'h20);
      check("t4_data_held", bus.mem_wdata, 32'h002080B3);
      check("t4_no_write", 32'(log_a.size()), 32'd0);
      bus.mem_ready = 1'b1;
      i = 0;
      while (k < 6 && i < 100) begin
         bus.in_valid  = 1'b1;
         bus.in_alu_op = st_op[k];
         bus.in_rd     = 5'(k + 1);
         if (bus.in_ready) begin
            tick();
            k++;
         end else begin
            tick();
         end
         i++;
      end
      bus.in_valid = 1'b0;
      wait_done(d0);
      check("t4_count", 32'(log_a.size()), 32'd6);
      for (int j = 0; j < 6; j++) begin
         check($sformatf("t4_addr%0d", j), 32'(log_a[j]), 32'h20 + 32'(j));
         check($sformatf("t4_data%0d", j), log_d[j], st_w[j]);
      end

      // illegal op in the middle
      log_a.delete(); log_d.delete(); d0 = done_cnt;
      start_load(8'h40, 9'd3);
      check("t5_illegal_clear", 32'(bus.illegal_op), 32'd0);
      send(4'd8, 5'd7, 5'd1, 5'd2);
      send(4'd12, 5'd9, 5'd1, 5'd2);
      send(4'd6, 5'd8, 5'd1, 5'd2);
      wait_done(d0);
      check("t5_count", 32'(log_a.size()), 32'd3);
      check("t5_data0", log_d[0], 32'h0020E3B3);
      check("t5_data1", log_d[1], 32'h00000033);
      check("t5_data2", log_d[2], 32'h0020D433);
      check("t5_addr2", 32'(log_a[2]), 32'h42);
      check("t5_illegal_sticky", 32'(bus.illegal_op), 32'd1);

      // reset mid-load after two words
      log_a.delete(); log_d.delete(); d0 = done_cnt;
      bus.mem_ready = 1'b0;
      start_load(8'h80, 9'd4);
      check("t6_illegal_cleared", 32'(bus.illegal_op), 32'd0);
      send(4'd9, 5'd1, 5'd2, 5'd3);
      send(4'd9, 5'd2, 5'd2, 5'd3);
      send(4'd9, 5'd3, 5'd2, 5'd3);
      send(4'd9, 5'd4, 5'd2, 5'd3);
      tick();
      bus.mem_ready = 1'b1;
      tick();
      tick();
      bus.mem_ready = 1'b0;
      check("t6_partial", 32'(log_a.size()), 32'd2);
      check("t6_addr1", 32'(log_a[1]), 32'h81);
      check("t6_data1", log_d[1], 32'h00317133);
      rst = 1'b1;
      tick();
      check("t6_rst_we", 32'(bus.mem_we), 32'd0);
      check("t6_rst_busy", 32'(bus.busy), 32'd0);
      check("t6_rst_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      check("t6_no_done", 32'(done_cnt - d0), 32'd0);
      log_a.delete(); log_d.delete(); d0 = done_cnt;
      start_load(8'h90, 9'd1);
      send(4'd0, 5'd3, 5'd1, 5'd2);
      wait_done(d0);
      check("t6_fresh_count", 32'(log_a.size()), 32'd1);
      check("t6_fresh_addr", 32'(log_a[0]), 32'h90);
      check("t6_fresh_data", log_d[0], 32'h002081B3);

      // zero-length load
      log_a.delete(); log_d.delete(); d0 = done_cnt;
      start_load(8'h50, 9'd0);
      check("t7_done_early", 32'(bus.done), 32'd0);
      tick();
      check("t7_done_pulse", 32'(bus.done), 32'd1);
      tick();
      check("t7_done_fall", 32'(bus.done), 32'd0);
      check("t7_no_write", 32'(log_a.size()), 32'd0);
      check("t7_done_once", 32'(done_cnt - d0), 32'd1);

      // start during RUN is ignored
      log_a.delete(); log_d.delete(); d0 = done_cnt;
      start_load(8'hA0, 9'd2);
      send(4'd0, 5'd3, 5'd1, 5'd2);
      start_load(8'hC0, 9'd1);
      send(4'd1, 5'd5, 5'd6, 5'd7);
      wait_done(d0);
      check("t8_count", 32'(log_a.size()), 32'd2);
      check("t8_addr0", 32'(log_a[0]), 32'hA0);
      check("t8_addr1", 32'(log_a[1]), 32'hA1);
      check("t8_data1", log_d[1], 32'h407302B3);
      check("t8_done_once", 32'(done_cnt - d0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
